reset_request_aggregator: RTL

- Fan-in counterpart to the fixed clock broadcast node.
- The broadcast node drives one clock/reset pair to several sink domains. This block collects per-sink reset requests and ready acknowledgements and produces one stretched upstream reset that feeds the broadcast input.
- Requests are batched. Each batch runs as: hold reset, release, then wait for every sink in the batch to report ready or time out.

---
 rtl/reset_request_aggregator_if.sv | 42 ++++
 rtl/reset_request_aggregator.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/reset_request_aggregator_if.sv
// Sink-side bundle for reset_request_aggregator: per-sink request/ready inputs and status outputs.
// With RESET_AGG_STATS_EN defined the bundle also carries the 16-bit batch_count.
interface reset_request_aggregator_if #(
  parameter int NUM_SINKS = 5
);
  logic [NUM_SINKS-1:0] sink_reset_req;
  logic [NUM_SINKS-1:0] sink_ready;
  logic                 auto_out_reset;
  logic                 busy;
  logic [NUM_SINKS-1:0] pending_mask;
  logic [NUM_SINKS-1:0] batch_mask;
  logic                 timeout_err;
`ifdef RESET_AGG_STATS_EN
  logic [15:0]          batch_count;
`endif

  modport slave (
    input  sink_reset_req,
    input  sink_ready,
`ifdef RESET_AGG_STATS_EN
    output batch_count,
`endif
    output auto_out_reset,
    output busy,
    output pending_mask,
    output batch_mask,
    output timeout_err
  );

  modport master (
    output sink_reset_req,
    output sink_ready,
`ifdef RESET_AGG_STATS_EN
    input  batch_count,
`endif
    input  auto_out_reset,
    input  busy,
    input  pending_mask,
    input  batch_mask,
    input  timeout_err
  );
endinterface

// File: rtl/reset_request_aggregator.sv
// Batches per-sink reset requests into one stretched upstream reset and waits for the batch to report ready.
// Optional macro RESET_AGG_STATS_EN adds a saturating 16-bit count of completed hold phases.
module reset_request_aggregator #(
  parameter int NUM_SINKS      = 5,
  parameter int HOLD_CYCLES    = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                        clock,
  input logic                        reset,
  reset_request_aggregator_if.slave  agg
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    POR_HOLD   = 2'd0,
    ASSERT     = 2'd1,
    WAIT_READY = 2'd2,
    IDLE       = 2'd3
  } state_t;

  logic [NUM_SINKS-1:0] req_sync_q [SYNC_STAGES];
  logic [NUM_SINKS-1:0] rdy_sync_q [SYNC_STAGES];
  logic [NUM_SINKS-1:0] req_prev_q;
  logic [NUM_SINKS-1:0] req_edge_s;
  logic [NUM_SINKS-1:0] ready_s;

  state_t               state_q, state_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
  logic [NUM_SINKS-1:0] pending_q, pending_d;
  logic [NUM_SINKS-1:0] batch_q, batch_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 auto_out_reset_q, auto_out_reset_d;
  logic                 busy_q, busy_d;

  // Input synchronizers plus the delayed last stage used for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        req_sync_q[i] <= '0;
        rdy_sync_q[i] <= '0;
      end
      req_prev_q <= '0;
    end else begin
      req_sync_q[0] <= agg.sink_reset_req;
      rdy_sync_q[0] <= agg.sink_ready;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        req_sync_q[i] <= req_sync_q[i-1];
        rdy_sync_q[i] <= rdy_sync_q[i-1];
      end
      req_prev_q <= req_sync_q[SYNC_STAGES-1];
    end
  end

  assign req_edge_s = req_sync_q[SYNC_STAGES-1] & ~req_prev_q;
  assign ready_s    = rdy_sync_q[SYNC_STAGES-1];

  // Batch sequencing: hold, release, then wait for the batch to report ready or time out
  always_comb begin
    state_d       = state_q;
    hold_cnt_d    = hold_cnt_q;
    to_cnt_d      = to_cnt_q;
    pending_d     = pending_q;
    batch_d       = batch_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      POR_HOLD, ASSERT: begin
        batch_d = batch_q | req_edge_s;
        if (hold_cnt_q == '0) begin
          state_d  = WAIT_READY;
          to_cnt_d = TO_LOAD;
        end else begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end
      end
      WAIT_READY: begin
        // Edges on the exit cycle still land here, so IDLE picks them up next cycle
        pending_d = pending_q | req_edge_s;
        if ((ready_s & batch_q) == batch_q) begin
          state_d = IDLE;
        end else if (to_cnt_q == '0) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          to_cnt_d = to_cnt_q - TO_W'(1);
        end
      end
      IDLE: begin
        if ((pending_q | req_edge_s) != '0) begin
          batch_d    = pending_q | req_edge_s;
          pending_d  = '0;
          hold_cnt_d = HOLD_LOAD;
          state_d    = ASSERT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d    = POR_HOLD;
        hold_cnt_d = HOLD_LOAD;
      end
    endcase
    auto_out_reset_d = (state_d == POR_HOLD) || (state_d == ASSERT);
    busy_d           = (state_d != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= POR_HOLD;
      hold_cnt_q       <= HOLD_LOAD;
      to_cnt_q         <= TO_LOAD;
      pending_q        <= '0;
      batch_q          <= {NUM_SINKS{1'b1}};
      timeout_err_q    <= 1'b0;
      auto_out_reset_q <= 1'b1;
      busy_q           <= 1'b1;
    end else begin
      state_q          <= state_d;
      hold_cnt_q       <= hold_cnt_d;
      to_cnt_q         <= to_cnt_d;
      pending_q        <= pending_d;
      batch_q          <= batch_d;
      timeout_err_q    <= timeout_err_d;
      auto_out_reset_q <= auto_out_reset_d;
      busy_q           <= busy_d;
    end
  end

  assign agg.auto_out_reset = auto_out_reset_q;
  assign agg.busy           = busy_q;
  assign agg.pending_mask   = pending_q;
  assign agg.batch_mask     = batch_q;
  assign agg.timeout_err    = timeout_err_q;

`ifdef RESET_AGG_STATS_EN
  logic [15:0] batch_count_q, batch_count_d;

  // Count every end of a hold phase, saturating at the top
  always_comb begin
    batch_count_d = batch_count_q;
    if (((state_q == POR_HOLD) || (state_q == ASSERT)) && (state_d == WAIT_READY)
        && (batch_count_q != 16'hFFFF)) begin
      batch_count_d = batch_count_q + 16'd1;
    end else begin
      batch_count_d = batch_count_q;
    end
  end

  // Statistics register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      batch_count_q <= 16'd0;
    end else begin
      batch_count_q <= batch_count_d;
    end
  end

  assign agg.batch_count = batch_count_q;
`endif

endmodule
